ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte to the keyboard (LED set 0xED, reset 0xFF, enable 0xF4) using the PS/2 host-request protocol. It shares the open-drain PS2_CLK/PS2_DAT lines with the receive-side `ps2_decoder`, and holds `rx_inhibit` high while a frame is in flight. It runs in the CLOCK_50 domain and is driven by a bus-mapped command register.

## Interface
- `INHIBIT_CYCLES`, default 5000: clock-low hold before the request (100 µs at 50 MHz).
- `FIRST_EDGE_CYCLES`, default 750000: limit from clock release to the first device falling edge (15 ms).
- `FRAME_CYCLES`, default 100000: limit from the first falling edge to the ACK edge (2 ms).
- `CLOCK_50`  in  1  system clock.
- `KEY0`  in  1  reset, asynchronous, active-low.
- `ps2_clk_async`  in  1  raw PS2_CLK pin.
- `ps2_data_async`  in  1  raw PS2_DAT pin.
- `ps2_clk_oe`  out  1  1 = drive PS2_CLK low; 0 = release.
- `ps2_dat_oe`  out  1  1 = drive PS2_DAT low; 0 = release.
- `tx_data`  in  8  command byte.
- `tx_valid`  in  1  request; byte accepted when `tx_valid && tx_ready`.
- `tx_ready`  out  1  high only in IDLE.
- `tx_done`  out  1  one-cycle pulse after an ACKed frame.
- `tx_error`  out  1  one-cycle pulse on failure.
- `err_code`  out  2  0 = none, 1 = no first edge, 2 = frame timeout, 3 = NACK. Held until the next accept.
- `rx_inhibit`  out  1  high from accept until return to IDLE.

## Operation
- Pin inputs pass through 2-flop synchronizers. `fall` = previous synced clock is 1 and current synced clock is 0.
- On accept: latch `tx_data`; latch parity = ~^tx_data (odd parity); clear `err_code`.
- States:
  - IDLE: both oe = 0.
  - INHIBIT: `ps2_clk_oe` = 1 for INHIBIT_CYCLES cycles.
  - START: one cycle with `ps2_clk_oe` = 1 and `ps2_dat_oe` = 1.
  - WAIT_EDGE: `ps2_clk_oe` = 0, `ps2_dat_oe` = 1 (this is the start bit).
  - SEND: bit counter 0..9.
  - ACK.
  - WAIT_IDLE.
- SEND drives one bit per `fall`:
  - Falls 1–8: data bits, LSB first. `ps2_dat_oe` = ~bit.
  - Fall 9: parity bit.
  - Fall 10: stop bit, `ps2_dat_oe` = 0.
- ACK: on fall 11, sample synced data. Data 0 → WAIT_IDLE. Data 1 → NACK error.
- WAIT_IDLE: wait until both synced lines are 1, then pulse `tx_done` and return to IDLE.
- Timeouts (one counter, reset on each state entry where noted):
  - In WAIT_EDGE, the counter reaching FIRST_EDGE_CYCLES → error 1.
  - The counter is reset on the first fall. SEND, ACK and WAIT_IDLE share it, and reaching FRAME_CYCLES → error 2.
- On any error: both oe = 0, `tx_error` pulses, state returns to IDLE.
- `tx_valid` while not ready is ignored; the byte is not queued.
- A device frame in progress at accept is aborted by the inhibit (host priority). Any partial receive is masked by `rx_inhibit`.
- Falls seen while the host itself drives the clock low (INHIBIT, START) are ignored.

## Timing
- Reset values: `ps2_clk_oe` = 0, `ps2_dat_oe` = 0, `tx_ready` = 1 (IDLE), `tx_done` = 0, `tx_error` = 0, `err_code` = 0, `rx_inhibit` = 0. All counters and the state are cleared.
- Reset asserted mid-frame releases both lines immediately (asynchronous). No done or error pulse is generated.
- Accept at edge N: `ps2_clk_oe` and `rx_inhibit` go high at edge N+1. START follows INHIBIT_CYCLES cycles later.
- Pin fall to `fall` asserted: 3 cycles. `fall` to `ps2_dat_oe` update: 1 cycle. Total ≤ 4 cycles, far inside the device clock-low half-period (~30 µs).
- `tx_done` / `tx_error` pulse on the cycle where `tx_ready` returns high. `tx_done` and `tx_error` are never asserted in the same cycle.
- Counter width: $clog2(max(FIRST_EDGE_CYCLES, FRAME_CYCLES) + 1).

## Structure
- Package `ps2_pkg` holds:
  - the state enum;
  - `err_code` constants;
  - the odd-parity function;
  - shared command constants (0xED, 0xFF, 0xF4), also used by the decoder side.
- Sub-module `ps2_sync_edge`: 2-flop synchronizer plus falling-edge detector. It is instantiated for the clock, with the data path synchronizer only.
- The top level ties each pin as tri-state: PS2_CLK = `ps2_clk_oe` ? 0 : Z, and likewise for PS2_DAT.

## Test plan
- Send 0xED to a device model that ACKs:
  - observe clock low 5000 cycles, then data low with clock released;
  - device samples bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1;
  - `tx_done` pulses once and `err_code` = 0.
- Send 0xF4 → parity sampled as 0. Send 0xFF → parity 1. Both frames complete with `tx_done`.
- Device never clocks → `tx_error` pulse FIRST_EDGE_CYCLES after clock release, `err_code` = 1, both oe = 0, `tx_ready` = 1.
- Device stops after fall 5 → `tx_error` pulse with `err_code` = 2, FRAME_CYCLES after fall 1.
- Device leaves data high on the ACK edge → `err_code` = 3 with `tx_error` pulse. A second `tx_valid` held during the frame is not accepted until IDLE.
- KEY0 low at fall 6 → both oe = 0 immediately and `rx_inhibit` = 0. After release, a new 0xFF send completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-side blocks (transmitter and the
// receive-side decoder):
//   - ps2_tx_state_e : transmitter FSM states
//   - ERR_*          : err_code values reported by ps2_host_tx
//   - PS2_CMD_*      : command bytes the host sends to the keyboard
//   - odd_parity()   : parity bit that makes the 9-bit (data + parity) odd
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_EDGE = 3'd3,
        ST_SEND      = 3'd4,
        ST_ACK       = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } ps2_tx_state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_NO_EDGE  = 2'd1;
    localparam logic [1:0] ERR_FRAME_TO = 2'd2;
    localparam logic [1:0] ERR_NACK     = 2'd3;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

    // Odd parity: 1 when the data byte holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
// Two-flop synchronizer for a raw PS/2 pin, with an optional registered
// falling-edge detector. A pin fall shows up on `fall` 3 cycles later as a
// single-cycle pulse. Both flops reset to 1 (idle bus level) so that leaving
// reset never fakes a falling edge.
//   clk       in  1  system clock
//   rst_n     in  1  asynchronous active-low reset
//   pin_async in  1  raw pin
//   level     out 1  synchronized pin level
//   fall      out 1  one-cycle pulse per falling edge (0 when EDGE_EN = 0)
// ---------------------------------------------------------------------------
module ps2_sync_edge #(
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_async,
    output logic level,
    output logic fall
);

    logic [1:0] sync_r;

    // Two-stage metastability filter on the raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], pin_async};
        end
    end

    assign level = sync_r[1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_r;
            logic fall_r;

            // Remember the previous synced level and register the 1->0 transition.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_r <= 1'b1;
                    fall_r <= 1'b0;
                end else begin
                    prev_r <= sync_r[1];
                    fall_r <= prev_r & ~sync_r[1];
                end
            end

            assign fall = fall_r;
        end else begin : g_no_edge
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte using the host
// request sequence: hold the clock low, pull data low (start bit), release
// the clock and then place each bit on the device's falling clock edges.
// The board level ties the open-drain pins as
//   PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz,  PS2_DAT = ps2_dat_oe ? 1'b0 : 1'bz.
//   CLOCK_50        in  1  system clock
//   KEY0            in  1  asynchronous active-low reset
//   ps2_clk_async   in  1  raw PS2_CLK pin
//   ps2_data_async  in  1  raw PS2_DAT pin
//   ps2_clk_oe      out 1  1 = pull PS2_CLK low
//   ps2_dat_oe      out 1  1 = pull PS2_DAT low
//   tx_data         in  8  command byte
//   tx_valid        in  1  request (accepted when tx_valid && tx_ready)
//   tx_ready        out 1  high only in IDLE
//   tx_done         out 1  one-cycle pulse after an ACKed frame
//   tx_error        out 1  one-cycle pulse on failure
//   err_code        out 2  last failure reason, cleared on accept
//   rx_inhibit      out 1  masks the receive decoder while a frame is active
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES    = 5000,
    parameter int unsigned FIRST_EDGE_CYCLES = 750000,
    parameter int unsigned FRAME_CYCLES      = 100000
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic       ps2_clk_async,
    input  logic       ps2_data_async,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    output logic       rx_inhibit
);

    localparam int unsigned TIMEOUT_MAX =
        (FIRST_EDGE_CYCLES > FRAME_CYCLES) ? FIRST_EDGE_CYCLES : FRAME_CYCLES;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST    = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIRST_EDGE_LAST = CNT_W'(FIRST_EDGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST      = CNT_W'(FRAME_CYCLES - 1);

    ps2_tx_state_e    state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       bit_cnt_r;
    // {stop, parity, data[7:0]}: index = bit sent on fall (index + 1)
    logic [9:0]       frame_r;

    logic clk_level_s;
    logic clk_fall_s;
    logic dat_level_s;
    logic data_fall_unused_s;
    logic inhibit_end_s;
    logic edge_to_s;
    logic frame_to_s;

    ps2_sync_edge #(.EDGE_EN(1'b1)) u_clk_sync (
        .clk       (CLOCK_50),
        .rst_n     (KEY0),
        .pin_async (ps2_clk_async),
        .level     (clk_level_s),
        .fall      (clk_fall_s)
    );

    ps2_sync_edge #(.EDGE_EN(1'b0)) u_dat_sync (
        .clk       (CLOCK_50),
        .rst_n     (KEY0),
        .pin_async (ps2_data_async),
        .level     (dat_level_s),
        .fall      (data_fall_unused_s)
    );

    // ">=" rather than "==" so a fall landing on the limit cannot skip the check.
    assign inhibit_end_s = (cnt_r >= INHIBIT_LAST);
    assign edge_to_s     = (cnt_r >= FIRST_EDGE_LAST);
    assign frame_to_s    = (cnt_r >= FRAME_LAST);

    // Transmit FSM: sequencing, timeout counter and all registered outputs.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            bit_cnt_r  <= 4'd0;
            frame_r    <= 10'd0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            err_code   <= ERR_NONE;
            rx_inhibit <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (tx_valid) begin
                        frame_r    <= {1'b1, odd_parity(tx_data), tx_data};
                        err_code   <= ERR_NONE;
                        cnt_r      <= '0;
                        ps2_clk_oe <= 1'b1;
                        rx_inhibit <= 1'b1;
                        tx_ready   <= 1'b0;
                        state_r    <= ST_INHIBIT;
                    end
                end

                // Falls seen here come from our own clock pull and are ignored.
                ST_INHIBIT: begin
                    if (inhibit_end_s) begin
                        ps2_dat_oe <= 1'b1;
                        cnt_r      <= '0;
                        state_r    <= ST_START;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_START: begin
                    ps2_clk_oe <= 1'b0;
                    cnt_r      <= '0;
                    state_r    <= ST_WAIT_EDGE;
                end

                // Data held low (start bit) until the device starts clocking.
                ST_WAIT_EDGE: begin
                    if (edge_to_s) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_error   <= 1'b1;
                        err_code   <= ERR_NO_EDGE;
                        tx_ready   <= 1'b1;
                        rx_inhibit <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else if (clk_fall_s) begin
                        ps2_dat_oe <= ~frame_r[0];
                        bit_cnt_r  <= 4'd1;
                        cnt_r      <= '0;
                        state_r    <= ST_SEND;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                // Falls 2..10: data bits 1..7, parity, stop (stop releases data).
                ST_SEND: begin
                    if (frame_to_s) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_error   <= 1'b1;
                        err_code   <= ERR_FRAME_TO;
                        tx_ready   <= 1'b1;
                        rx_inhibit <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (clk_fall_s) begin
                            ps2_dat_oe <= ~frame_r[bit_cnt_r];
                            if (bit_cnt_r == 4'd9) begin
                                state_r <= ST_ACK;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end
                end

                // Fall 11: the device pulls data low to acknowledge.
                ST_ACK: begin
                    if (frame_to_s || (clk_fall_s && dat_level_s)) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_error   <= 1'b1;
                        err_code   <= frame_to_s ? ERR_FRAME_TO : ERR_NACK;
                        tx_ready   <= 1'b1;
                        rx_inhibit <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (clk_fall_s) begin
                            state_r <= ST_WAIT_IDLE;
                        end
                    end
                end

                ST_WAIT_IDLE: begin
                    if (frame_to_s) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_error   <= 1'b1;
                        err_code   <= ERR_FRAME_TO;
                        tx_ready   <= 1'b1;
                        rx_inhibit <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else if (clk_level_s && dat_level_s) begin
                        tx_done    <= 1'b1;
                        tx_ready   <= 1'b1;
                        rx_inhibit <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    tx_ready   <= 1'b1;
                    rx_inhibit <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Self-checking bench for ps2_host_tx with a behavioural PS/2 keyboard on an
// open-drain bus. Expected frame bits come from a byte -> (LSB-first data,
// odd parity, stop) model; timing expectations come from the cycle counts of
// the protocol (inhibit length, timeouts, 4-cycle edge-to-response latency).
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH   = 50;
    localparam int FIRST = 2000;
    localparam int FRAME = 1500;

    logic       CLOCK_50 = 1'b0;
    logic       KEY0;
    logic       ps2_clk_async;
    logic       ps2_data_async;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic [1:0] err_code;
    logic       rx_inhibit;

    logic dev_clk_low;
    logic dev_dat_low;

    // Open-drain bus with pull-ups: either side can pull a line low.
    assign ps2_clk_async  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_async = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES    (INH),
        .FIRST_EDGE_CYCLES (FIRST),
        .FRAME_CYCLES      (FRAME)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .KEY0           (KEY0),
        .ps2_clk_async  (ps2_clk_async),
        .ps2_data_async (ps2_data_async),
        .ps2_clk_oe     (ps2_clk_oe),
        .ps2_dat_oe     (ps2_dat_oe),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_done        (tx_done),
        .tx_error       (tx_error),
        .err_code       (err_code),
        .rx_inhibit     (rx_inhibit)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Monitor: snapshot every done/error pulse and count accepts (rx_inhibit rises).
    int         evt_cnt = 0;
    int         evt_cyc = 0;
    logic       evt_done, evt_err, evt_ready, evt_clk_oe, evt_dat_oe, evt_inh;
    logic [1:0] evt_code;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         both_cnt = 0;
    int         inh_rise_cnt = 0;
    int         inh_rise_cyc = 0;
    logic       inh_prev = 1'b0;

    always @(negedge CLOCK_50) begin
        if (tx_done || tx_error) begin
            evt_cnt    <= evt_cnt + 1;
            evt_cyc    <= cyc;
            evt_done   <= tx_done;
            evt_err    <= tx_error;
            evt_code   <= err_code;
            evt_ready  <= tx_ready;
            evt_clk_oe <= ps2_clk_oe;
            evt_dat_oe <= ps2_dat_oe;
            evt_inh    <= rx_inhibit;
        end
        if (tx_done)              done_cnt <= done_cnt + 1;
        if (tx_error)             err_cnt  <= err_cnt + 1;
        if (tx_done && tx_error)  both_cnt <= both_cnt + 1;
        if (rx_inhibit && !inh_prev) begin
            inh_rise_cnt <= inh_rise_cnt + 1;
            inh_rise_cyc <= cyc;
        end
        inh_prev <= rx_inhibit;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int exp_done = 0;
    int exp_err = 0;
    int exp_acc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference frame: 8 data bits LSB first, odd parity, stop = 1.
    function automatic logic [9:0] expect_bits(input logic [7:0] b);
        logic [9:0] r;
        int v;
        int ones;
        v = b;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            r[i] = ((v % 2) == 1);
            ones += v % 2;
            v = v / 2;
        end
        r[8] = ((ones % 2) == 0);
        r[9] = 1'b1;
        return r;
    endfunction

    task automatic accept_byte(input logic [7:0] b, input bit hold);
        int n = 0;
        while (!tx_ready && n < 5000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check_eq("ready_before_accept", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        if (!hold) tx_valid = 1'b0;
        exp_acc++;
        check_eq("accept_clk_oe", ps2_clk_oe, 1);
        check_eq("accept_rx_inhibit", rx_inhibit, 1);
        check_eq("accept_ready_low", tx_ready, 0);
        check_eq("accept_err_clear", err_code, 0);
    endtask

    // Called on the first negedge after accept; ends on the first released-clock cycle.
    task automatic check_request(output int rel_cyc);
        int n = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n < 10 * INH) begin
            n++;
            @(negedge CLOCK_50);
        end
        check_eq("inhibit_cycles", n, INH);
        check_eq("start_clk_oe", ps2_clk_oe, 1);
        check_eq("start_dat_oe", ps2_dat_oe, 1);
        @(negedge CLOCK_50);
        check_eq("release_clk_oe", ps2_clk_oe, 0);
        check_eq("release_dat_oe", ps2_dat_oe, 1);
        rel_cyc = cyc;
    endtask

    // Keyboard model: n_falls clock pulses, samples bits 1..10 before each rise,
    // ACKs (or not) on pulse 11; optionally returns with the last pulse held low.
    task automatic device_run(input int n_falls, input bit ack, input bit hold_low,
                              input int half, output logic [9:0] got, output int fall1_cyc);
        got = 10'd0;
        fall1_cyc = 0;
        repeat (5 + $urandom_range(30)) @(negedge CLOCK_50);
        for (int k = 1; k <= n_falls; k++) begin
            if (k == 11) begin
                dev_dat_low = ack;
                repeat (3) @(negedge CLOCK_50);
            end
            dev_clk_low = 1'b1;
            if (k == 1) fall1_cyc = cyc;
            if (hold_low && k == n_falls) return;
            repeat (half) @(negedge CLOCK_50);
            if (k <= 10) got[k-1] = ps2_data_async;
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            repeat (half) @(negedge CLOCK_50);
        end
    endtask

    task automatic wait_result(input int start, input logic [1:0] code, input string tag);
        int n = 0;
        while (evt_cnt <= start && n < 4 * FIRST) begin
            @(negedge CLOCK_50);
            n++;
        end
        check_eq({tag, "_event_seen"}, evt_cnt > start, 1);
        check_eq({tag, "_err_code"}, evt_code, code);
        check_eq({tag, "_done"}, evt_done, code == 2'd0);
        check_eq({tag, "_error"}, evt_err, code != 2'd0);
        check_eq({tag, "_ready"}, evt_ready, 1);
        check_eq({tag, "_oe"}, {evt_clk_oe, evt_dat_oe}, 0);
        check_eq({tag, "_rx_inhibit"}, evt_inh, 0);
        if (code == 2'd0) exp_done++;
        else              exp_err++;
    endtask

    task automatic run_frame(input logic [7:0] b, input int half, input string tag);
        int start;
        int rel;
        int f1;
        logic [9:0] got;
        start = evt_cnt;
        accept_byte(b, 1'b0);
        check_request(rel);
        device_run(11, 1'b1, 1'b0, half, got, f1);
        check_eq({tag, "_bits"}, got, expect_bits(b));
        wait_result(start, 2'd0, tag);
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int rel;
        int f1;
        int n;
        logic [9:0] got;

        KEY0 = 1'b0;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge CLOCK_50);
        check_eq("rst_clk_oe", ps2_clk_oe, 0);
        check_eq("rst_dat_oe", ps2_dat_oe, 0);
        check_eq("rst_ready", tx_ready, 1);
        check_eq("rst_done", tx_done, 0);
        check_eq("rst_error", tx_error, 0);
        check_eq("rst_err_code", err_code, 0);
        check_eq("rst_rx_inhibit", rx_inhibit, 0);
        KEY0 = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        // Known commands: 0xED (parity 1), 0xF4 (parity 0), 0xFF (parity 1).
        run_frame(PS2_CMD_SET_LED, 20, "cmd_ed");
        run_frame(PS2_CMD_ENABLE, 25, "cmd_f4");
        run_frame(PS2_CMD_RESET, 18, "cmd_ff");

        // Device never clocks.
        start = evt_cnt;
        accept_byte(PS2_CMD_ENABLE, 1'b0);
        check_request(rel);
        wait_result(start, 2'd1, "no_edge");
        check_eq("no_edge_latency", evt_cyc - rel, FIRST);

        // Device stops after fall 5; limit counts from fall 1 as seen by the host
        // (3 cycles sync/detect + 1 cycle to act).
        start = evt_cnt;
        accept_byte(PS2_CMD_SET_LED, 1'b0);
        check_request(rel);
        device_run(5, 1'b0, 1'b0, 20, got, f1);
        wait_result(start, 2'd2, "frame_to");
        check_eq("frame_to_latency", evt_cyc - f1, FRAME + 4);

        // NACK, with a second request held during the whole frame.
        start = evt_cnt;
        accept_byte(PS2_CMD_SET_LED, 1'b1);
        tx_data = 8'h5A;
        check_request(rel);
        device_run(11, 1'b0, 1'b0, 15, got, f1);
        check_eq("nack_bits", got, expect_bits(PS2_CMD_SET_LED));
        wait_result(start, 2'd3, "nack");
        n = 0;
        while (inh_rise_cyc <= evt_cyc && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        tx_valid = 1'b0;
        exp_acc++;
        check_eq("held_accept_cycle", inh_rise_cyc - evt_cyc, 1);
        start = evt_cnt;
        n = 0;
        while (!(!ps2_clk_oe && ps2_dat_oe) && n < 1000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check_eq("held_reached_release", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
        device_run(11, 1'b1, 1'b0, 20, got, f1);
        check_eq("held_bits", got, expect_bits(8'h5A));
        wait_result(start, 2'd0, "held");

        // Reset asserted while the device holds the clock low for fall 6.
        accept_byte(PS2_CMD_RESET, 1'b0);
        check_request(rel);
        device_run(6, 1'b0, 1'b1, 20, got, f1);
        repeat (2) @(negedge CLOCK_50);
        #2 KEY0 = 1'b0;
        #1;
        check_eq("midrst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        check_eq("midrst_rx_inhibit", rx_inhibit, 0);
        check_eq("midrst_ready", tx_ready, 1);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        KEY0 = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        run_frame(PS2_CMD_RESET, 20, "after_rst");

        // Random bytes and device clock rates.
        for (int i = 0; i < 4; i++) begin
            run_frame(8'($urandom_range(255)), $urandom_range(15, 30), "rand");
        end

        repeat (5) @(negedge CLOCK_50);
        check_eq("total_done", done_cnt, exp_done);
        check_eq("total_error", err_cnt, exp_err);
        check_eq("done_and_error_same_cycle", both_cnt, 0);
        check_eq("total_accepts", inh_rise_cnt, exp_acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
